// File: rtl/cp0_wbuf_fwd_pkg.sv
// Shared definitions for the CP0 write buffer: register addresses, default widths,
// the queued-entry record and a small popcount helper.
package cp0_wbuf_fwd_pkg;

    localparam int CP0_AW = 5;
    localparam int CP0_DW = 32;

    localparam logic [CP0_AW-1:0] CP0_STATUS = 5'd12;
    localparam logic [CP0_AW-1:0] CP0_CAUSE  = 5'd13;
    localparam logic [CP0_AW-1:0] CP0_EPC    = 5'd14;

    typedef struct packed {
        logic              valid;
        logic [CP0_AW-1:0] addr;
        logic [CP0_DW-1:0] data;
    } cp0_entry_t;

    function automatic int unsigned cp0_popcount(input logic [31:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cp0_wbuf_fwd_if.sv
// Bus bundle between WB stage, the CP0 write buffer and the CP0 register file.
interface cp0_wbuf_fwd_if #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int NUM_RD    = 3,
    parameter int AW        = 5,
    parameter int DW        = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_LANES-1:0]    wr_en_i;
    logic [NUM_LANES*AW-1:0] wr_addr_i;
    logic [NUM_LANES*DW-1:0] wr_data_i;
    logic                    full_o;
    logic                    empty_o;
    logic [CW-1:0]           count_o;
    logic                    cp0_we_o;
    logic [AW-1:0]           cp0_waddr_o;
    logic [DW-1:0]           cp0_wdata_o;
    logic                    cp0_wack_i;
    logic [NUM_RD*AW-1:0]    rd_addr_i;
    logic [NUM_RD*DW-1:0]    cp0_rdata_i;
    logic [NUM_RD*DW-1:0]    rd_data_o;
    logic [NUM_RD-1:0]       rd_hit_o;

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, cp0_wack_i, rd_addr_i, cp0_rdata_i,
        output full_o, empty_o, count_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o,
               rd_data_o, rd_hit_o
    );

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, cp0_wack_i, rd_addr_i, cp0_rdata_i,
        input  full_o, empty_o, count_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o,
               rd_data_o, rd_hit_o
    );

endinterface

// File: rtl/cp0_wbuf_fwd_match.sv
// Priority search for one read port: youngest incoming lane, then youngest queued
// entry, otherwise the raw CP0 register-file value.
module cp0_fwd_match #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int AW        = 5,
    parameter int DW        = 32
) (
    input  logic [NUM_LANES-1:0]      lane_en_i,
    input  logic [NUM_LANES*AW-1:0]   lane_addr_i,
    input  logic [NUM_LANES*DW-1:0]   lane_data_i,
    input  logic [DEPTH-1:0]          ent_valid_i,
    input  logic [DEPTH*AW-1:0]       ent_addr_i,
    input  logic [DEPTH*DW-1:0]       ent_data_i,
    input  logic [$clog2(DEPTH)-1:0]  tail_i,
    input  logic [AW-1:0]             rd_addr_i,
    input  logic [DW-1:0]             cp0_rdata_i,
    output logic [DW-1:0]             rd_data_o,
    output logic                      rd_hit_o
);
    localparam int PW = $clog2(DEPTH);

    // Oldest-to-youngest sweep so the last match wins; lanes sweep after the buffer.
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          match_v;
        logic [DW-1:0] data_v;
        logic          hit_v;
        idx_v   = {PW{1'b0}};
        match_v = 1'b0;
        data_v  = cp0_rdata_i;
        hit_v   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx_v   = tail_i - PW'(i + 1);
            match_v = ent_valid_i[idx_v] && (ent_addr_i[idx_v*AW +: AW] == rd_addr_i);
            data_v  = match_v ? ent_data_i[idx_v*DW +: DW] : data_v;
            hit_v   = hit_v | match_v;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            match_v = lane_en_i[k] && (lane_addr_i[k*AW +: AW] == rd_addr_i);
            data_v  = match_v ? lane_data_i[k*DW +: DW] : data_v;
            hit_v   = hit_v | match_v;
        end
        rd_data_o = data_v;
        rd_hit_o  = hit_v;
    end

endmodule

// File: rtl/cp0_wbuf_fwd.sv
// CP0 write buffer: queues up to NUM_LANES committed writes per cycle in program
// order, drains one per acknowledged cycle, and forwards pending values to readers.
module cp0_wbuf_fwd
    import cp0_wbuf_fwd_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int NUM_RD    = 3,
    parameter int AW        = CP0_AW,
    parameter int DW        = CP0_DW
) (
    input  logic          clk,
    input  logic          rst,
    cp0_wbuf_fwd_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;

    logic                 full_s;
    logic                 empty_s;
    logic                 cp0_we_s;
    logic                 pop_s;
    logic [NUM_LANES-1:0] push_en_s;
    logic [CW-1:0]        push_cnt_s;

    // Full is judged on registered occupancy only, so a same-cycle pop never unblocks WB.
    assign full_s     = (CW'(DEPTH) - count_q) < CW'(NUM_LANES);
    assign empty_s    = (count_q == {CW{1'b0}});
    assign cp0_we_s   = valid_q[head_q];
    assign pop_s      = cp0_we_s & bus.cp0_wack_i;
    assign push_en_s  = bus.wr_en_i & {NUM_LANES{~full_s}};
    assign push_cnt_s = CW'(cp0_popcount(32'(push_en_s)));

    // Next-state: retire the head on ack, then pack enabled lanes into slots from tail.
    always_comb begin
        logic [PW-1:0] slot_v;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        slot_v  = tail_q;
        valid_d[head_q] = pop_s ? 1'b0 : valid_q[head_q];
        for (int k = 0; k < NUM_LANES; k++) begin
            valid_d[slot_v] = push_en_s[k] ? 1'b1 : valid_d[slot_v];
            addr_d[slot_v]  = push_en_s[k] ? bus.wr_addr_i[k*AW +: AW] : addr_d[slot_v];
            data_d[slot_v]  = push_en_s[k] ? bus.wr_data_i[k*DW +: DW] : data_d[slot_v];
            slot_v          = slot_v + PW'(push_en_s[k]);
        end
        tail_d  = slot_v;
        head_d  = head_q + PW'(pop_s);
        count_d = count_q + push_cnt_s - CW'(pop_s);
    end

    // Pointer, occupancy and entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            valid_q <= {DEPTH{1'b0}};
            addr_q  <= {(DEPTH*AW){1'b0}};
            data_q  <= {(DEPTH*DW){1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.full_o      = full_s;
    assign bus.empty_o     = empty_s;
    assign bus.count_o     = count_q;
    assign bus.cp0_we_o    = cp0_we_s;
    assign bus.cp0_waddr_o = cp0_we_s ? addr_q[head_q] : {AW{1'b0}};
    assign bus.cp0_wdata_o = cp0_we_s ? data_q[head_q] : {DW{1'b0}};

    wire [NUM_RD*DW-1:0] rd_data_s;
    wire [NUM_RD-1:0]    rd_hit_s;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        cp0_fwd_match #(
            .NUM_LANES (NUM_LANES),
            .DEPTH     (DEPTH),
            .AW        (AW),
            .DW        (DW)
        ) u_match (
            .lane_en_i   (push_en_s),
            .lane_addr_i (bus.wr_addr_i),
            .lane_data_i (bus.wr_data_i),
            .ent_valid_i (valid_q),
            .ent_addr_i  (addr_q),
            .ent_data_i  (data_q),
            .tail_i      (tail_q),
            .rd_addr_i   (bus.rd_addr_i[r*AW +: AW]),
            .cp0_rdata_i (bus.cp0_rdata_i[r*DW +: DW]),
            .rd_data_o   (rd_data_s[r*DW +: DW]),
            .rd_hit_o    (rd_hit_s[r])
        );
    end

    assign bus.rd_data_o = rd_data_s;
    assign bus.rd_hit_o  = rd_hit_s;

endmodule

// File: tb/tb_cp0_wbuf_fwd.sv
// Directed bench for cp0_wbuf_fwd: drain order checked by a scoreboard monitor,
// forwarding and occupancy checked at the falling edge.
module tb_cp0_wbuf_fwd;
    import cp0_wbuf_fwd_pkg::*;

    localparam int NL    = 2;
    localparam int DEPTH = 4;
    localparam int NRD   = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;

    localparam logic [31:0] RAW_CAUSE  = 32'hCA00_0013;
    localparam logic [31:0] RAW_STATUS = 32'h5A00_0012;
    localparam logic [31:0] RAW_EPC    = 32'hE9C0_0014;
    localparam logic [4:0]  A_OTHER    = 5'd9;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    cp0_entry_t exp_q[$];

    cp0_wbuf_fwd_if #(.NUM_LANES(NL), .DEPTH(DEPTH), .NUM_RD(NRD), .AW(AW), .DW(DW)) bus();

    cp0_wbuf_fwd #(.NUM_LANES(NL), .DEPTH(DEPTH), .NUM_RD(NRD), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic lanes(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        bus.wr_en_i   = en;
        bus.wr_addr_i = {a1, a0};
        bus.wr_data_i = {d1, d0};
    endtask

    task automatic idle();
        lanes(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic expect_drain(input logic [4:0] a, input logic [31:0] d);
        cp0_entry_t e;
        e.valid = 1'b1;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdd(input int r);
        return bus.rd_data_o[r*DW +: DW];
    endfunction

    // Scoreboard monitor: every accepted CP0 write must match the oldest expected entry.
    always @(negedge clk) begin
        cp0_entry_t e;
        if (rst === 1'b0 && bus.cp0_we_o === 1'b1 && bus.cp0_wack_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_unexpected: got addr %0d data %h, required no write",
                         bus.cp0_waddr_o, bus.cp0_wdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("drain_addr", 32'(bus.cp0_waddr_o), 32'(e.addr));
                chk("drain_data", bus.cp0_wdata_o, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.cp0_wack_i = 1'b0;
        idle();
        bus.rd_addr_i   = {CP0_EPC, CP0_STATUS, CP0_CAUSE};
        bus.cp0_rdata_i = {RAW_EPC, RAW_STATUS, RAW_CAUSE};

        @(negedge clk);
        chk("rst_we",    32'(bus.cp0_we_o),    32'd0);
        chk("rst_waddr", 32'(bus.cp0_waddr_o), 32'd0);
        chk("rst_wdata", bus.cp0_wdata_o,      32'd0);
        chk("rst_full",  32'(bus.full_o),      32'd0);
        chk("rst_empty", 32'(bus.empty_o),     32'd1);
        chk("rst_count", 32'(bus.count_o),     32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single Status write, forwarded from the lane then from the buffer.
        lanes(2'b01, CP0_STATUS, 32'h0000_FF01, 5'd0, 32'd0);
        bus.cp0_wack_i = 1'b1;
        expect_drain(CP0_STATUS, 32'h0000_FF01);
        @(negedge clk);
        chk("fwd_lane_status", rdd(1), 32'h0000_FF01);
        chk("hit_lane_status", 32'(bus.rd_hit_o[1]), 32'd1);
        chk("no_bypass_we",    32'(bus.cp0_we_o), 32'd0);
        chk("raw_cause",       rdd(0), RAW_CAUSE);
        chk("miss_cause",      32'(bus.rd_hit_o[0]), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("head_we",        32'(bus.cp0_we_o), 32'd1);
        chk("head_waddr",     32'(bus.cp0_waddr_o), 32'(CP0_STATUS));
        chk("fwd_buf_status", rdd(1), 32'h0000_FF01);
        step();
        @(negedge clk);
        chk("empty_after_ack", 32'(bus.empty_o), 32'd1);
        chk("raw_status",      rdd(1), RAW_STATUS);
        chk("miss_status",     32'(bus.rd_hit_o[1]), 32'd0);

        // Two lanes, same address: youngest forwards, both drain in order.
        step();
        lanes(2'b11, CP0_CAUSE, 32'h11, CP0_CAUSE, 32'h22);
        expect_drain(CP0_CAUSE, 32'h11);
        expect_drain(CP0_CAUSE, 32'h22);
        @(negedge clk);
        chk("fwd_lane_youngest", rdd(0), 32'h22);
        step();
        idle();
        @(negedge clk);
        chk("count_two",        32'(bus.count_o), 32'd2);
        chk("fwd_buf_youngest", rdd(0), 32'h22);
        step();
        @(negedge clk);
        chk("count_one",       32'(bus.count_o), 32'd1);
        chk("fwd_buf_remains", rdd(0), 32'h22);
        step();
        @(negedge clk);
        chk("empty_after_pair", 32'(bus.empty_o), 32'd1);

        // Fill to three with no ack; a write while full is dropped and not forwarded.
        step();
        bus.cp0_wack_i = 1'b0;
        lanes(2'b01, A_OTHER, 32'hA1, 5'd0, 32'd0);
        expect_drain(A_OTHER, 32'hA1);
        step();
        lanes(2'b01, A_OTHER, 32'hA2, 5'd0, 32'd0);
        expect_drain(A_OTHER, 32'hA2);
        step();
        lanes(2'b01, A_OTHER, 32'hA3, 5'd0, 32'd0);
        expect_drain(A_OTHER, 32'hA3);
        step();
        lanes(2'b01, CP0_STATUS, 32'hDEAD_BEEF, 5'd0, 32'd0);
        @(negedge clk);
        chk("count_three",      32'(bus.count_o), 32'd3);
        chk("full_three",       32'(bus.full_o), 32'd1);
        chk("no_fwd_when_full", rdd(1), RAW_STATUS);
        chk("no_hit_when_full", 32'(bus.rd_hit_o[1]), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("write_ignored_full", 32'(bus.count_o), 32'd3);
        step();
        bus.cp0_wack_i = 1'b1;
        @(negedge clk);
        chk("full_held_on_pop", 32'(bus.full_o), 32'd1);
        step();
        bus.cp0_wack_i = 1'b0;
        @(negedge clk);
        chk("count_after_pop", 32'(bus.count_o), 32'd2);
        chk("full_cleared",    32'(bus.full_o), 32'd0);

        // Push two while acking at count two, draining across the pointer wrap.
        step();
        lanes(2'b11, A_OTHER, 32'hB1, A_OTHER, 32'hB2);
        bus.cp0_wack_i = 1'b1;
        expect_drain(A_OTHER, 32'hB1);
        expect_drain(A_OTHER, 32'hB2);
        step();
        idle();
        @(negedge clk);
        chk("count_push_pop", 32'(bus.count_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        @(negedge clk);
        chk("empty_after_wrap", 32'(bus.empty_o), 32'd1);

        // Two EPC writes held in the buffer: youngest wins, other ports stay raw.
        step();
        bus.cp0_wack_i = 1'b0;
        lanes(2'b01, CP0_EPC, 32'hBFC0_0380, 5'd0, 32'd0);
        expect_drain(CP0_EPC, 32'hBFC0_0380);
        step();
        lanes(2'b01, CP0_EPC, 32'h8000_0180, 5'd0, 32'd0);
        expect_drain(CP0_EPC, 32'h8000_0180);
        @(negedge clk);
        chk("fwd_lane_over_buf", rdd(2), 32'h8000_0180);
        step();
        idle();
        @(negedge clk);
        chk("fwd_epc_youngest", rdd(2), 32'h8000_0180);
        chk("hit_epc",          32'(bus.rd_hit_o[2]), 32'd1);
        chk("raw_cause_epc",    rdd(0), RAW_CAUSE);
        chk("miss_cause_epc",   32'(bus.rd_hit_o[0]), 32'd0);

        // Third entry, then an asynchronous reset in the middle of the cycle.
        step();
        lanes(2'b01, CP0_CAUSE, 32'h33, 5'd0, 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("count_before_rst", 32'(bus.count_o), 32'd3);
        chk("fwd_cause_33",     rdd(0), 32'h33);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_we",     32'(bus.cp0_we_o), 32'd0);
        chk("arst_count",  32'(bus.count_o), 32'd0);
        chk("arst_empty",  32'(bus.empty_o), 32'd1);
        chk("arst_cause",  rdd(0), RAW_CAUSE);
        chk("arst_status", rdd(1), RAW_STATUS);
        chk("arst_epc",    rdd(2), RAW_EPC);
        chk("arst_hits",   32'(bus.rd_hit_o), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Recovery after reset: a fresh write forwards and drains normally.
        lanes(2'b01, CP0_CAUSE, 32'h44, 5'd0, 32'd0);
        bus.cp0_wack_i = 1'b1;
        expect_drain(CP0_CAUSE, 32'h44);
        @(negedge clk);
        chk("fwd_after_rst", rdd(0), 32'h44);
        step();
        idle();
        step();
        @(negedge clk);
        chk("empty_final",        32'(bus.empty_o), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
